// File: rtl/buffer_readout_sequencer.sv
// Buffer readout sequencer: merges N_SOURCES buffer streams into one output
// stream as header, each enabled source's beats in index order, then a
// trailer holding per-source beat counts.

// Per-source saturating beat counter.
module brs_cnt_lane #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   inc,
   output logic [COUNT_WIDTH-1:0] cnt
);
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   // Clear wins over increment; increment stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) cnt_d = '0;
      else if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

module buffer_readout_sequencer #(
   parameter int          N_SOURCES    = 2,
   parameter int          AXI_MM_WIDTH = 128,
   parameter int          COUNT_WIDTH  = 16,
   parameter logic [15:0] HEADER_MAGIC = 16'hA55A
) (
   input  logic                              clk,
   input  logic                              reset,
   // per-source streams, source i occupies data_in_data[i*AXI_MM_WIDTH +: AXI_MM_WIDTH]
   input  logic [N_SOURCES*AXI_MM_WIDTH-1:0] data_in_data,
   input  logic [N_SOURCES-1:0]              data_in_valid,
   input  logic [N_SOURCES-1:0]              data_in_last,
   output logic [N_SOURCES-1:0]              data_in_ready,
   // merged output stream
   output logic [AXI_MM_WIDTH-1:0]           data_out_data,
   output logic                              data_out_valid,
   output logic                              data_out_last,
   input  logic                              data_out_ready,
   // source enable mask, no back-pressure
   input  logic [N_SOURCES-1:0]              config_in_data,
   input  logic                              config_in_valid
);
   localparam int SEL_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

   if ((N_SOURCES < 1) || (N_SOURCES > 16)) begin : g_chk_nsrc
      $error("N_SOURCES must be in 1..16");
   end
   if (N_SOURCES * COUNT_WIDTH > AXI_MM_WIDTH) begin : g_chk_cnt
      $error("N_SOURCES*COUNT_WIDTH exceeds AXI_MM_WIDTH");
   end
   if (AXI_MM_WIDTH < 40) begin : g_chk_hdr
      $error("AXI_MM_WIDTH too narrow for header layout");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_STREAM, ST_TRAILER} state_t;

   state_t                                    state_q, state_d;
   logic [N_SOURCES-1:0]                      mask_q, mask_d;
   logic [SEL_W-1:0]                          sel_q, sel_d;
   logic [N_SOURCES-1:0][AXI_MM_WIDTH-1:0]    src_data;
   logic [N_SOURCES-1:0][COUNT_WIDTH-1:0]     cnt;
   logic [N_SOURCES-1:0]                      cnt_inc;
   logic                                      cnt_clr;
   logic [AXI_MM_WIDTH-1:0]                   hdr_word, trl_word;
   logic [SEL_W-1:0]                          first_idx, nxt_idx;
   logic                                      nxt_found;

   assign src_data = data_in_data;

   for (genvar g = 0; g < N_SOURCES; g++) begin : g_lane
      brs_cnt_lane #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clr   (cnt_clr),
         .inc   (cnt_inc[g]),
         .cnt   (cnt[g])
      );
   end

   // Lowest enabled source, and next enabled source above the current one.
   always_comb begin
      first_idx = '0;
      nxt_idx   = '0;
      nxt_found = 1'b0;
      for (int i = N_SOURCES - 1; i >= 0; i--) begin
         if (mask_q[i]) first_idx = SEL_W'(i);
         if (mask_q[i] && (i > int'(sel_q))) begin
            nxt_idx   = SEL_W'(i);
            nxt_found = 1'b1;
         end
      end
   end

   // Header and trailer words; both derive from registered state only, so
   // they stay stable while the consumer stalls.
   always_comb begin
      hdr_word = '0;
      hdr_word[AXI_MM_WIDTH-1 -: 16] = HEADER_MAGIC;
      hdr_word[23:16]                = 8'(N_SOURCES);
      hdr_word[15:0]                 = 16'(mask_q);
      trl_word = '0;
      for (int i = 0; i < N_SOURCES; i++) begin
         trl_word[i*COUNT_WIDTH +: COUNT_WIDTH] = mask_q[i] ? cnt[i] : '0;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      sel_d          = sel_q;
      data_out_data  = '0;
      data_out_valid = 1'b0;
      data_out_last  = 1'b0;
      data_in_ready  = '0;
      cnt_inc        = '0;
      cnt_clr        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (config_in_valid) mask_d = config_in_data;
            if (|(data_in_valid & mask_q)) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            data_out_valid = 1'b1;
            data_out_data  = hdr_word;
            if (data_out_ready) begin
               state_d = ST_STREAM;
               sel_d   = first_idx;
            end
         end
         ST_STREAM: begin
            data_out_valid         = data_in_valid[sel_q];
            data_out_data          = src_data[sel_q];
            data_in_ready[sel_q]   = data_out_ready;
            if (data_in_valid[sel_q] && data_out_ready) begin
               cnt_inc[sel_q] = 1'b1;
               if (data_in_last[sel_q]) begin
                  if (nxt_found) sel_d   = nxt_idx;
                  else           state_d = ST_TRAILER;
               end
            end
         end
         ST_TRAILER: begin
            data_out_valid = 1'b1;
            data_out_last  = 1'b1;
            data_out_data  = trl_word;
            if (data_out_ready) begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, mask and selection registers; reset re-enables every source.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mask_q  <= '1;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         sel_q   <= sel_d;
      end
   end
endmodule

// File: doc/buffer_readout_sequencer.md
BUFFER_READOUT_SEQUENCER -- requirements
Module: buffer_readout_sequencer

Interface
REQ-001 SHALL have parameter N_SOURCES, default 2: number of buffer output streams to sequence; legal range 1..16.
REQ-002 SHALL have parameter AXI_MM_WIDTH, default 128: width of every input and output data word.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16: width of each per-source beat counter; N_SOURCES*COUNT_WIDTH <= AXI_MM_WIDTH is required, checked by elaboration assertion.
REQ-004 SHALL have parameter HEADER_MAGIC, default 16'hA55A: tag placed in the header word.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port data_in, Axis_Parallel_If.Slave_Full (CHANNELS=N_SOURCES, DWIDTH=AXI_MM_WIDTH): per-source data/valid/last/ready.
REQ-008 SHALL have port data_out, Axis_If.Master_Full (DWIDTH=AXI_MM_WIDTH): merged output stream.
REQ-009 SHALL have port config_in, Axis_If.Slave_Realtime (DWIDTH=N_SOURCES): source enable mask; bit i set = source i enabled.

Function
REQ-010 SHALL implement FSM states IDLE, HEADER, STREAM, TRAILER.
REQ-011 SHALL latch config_in.data into the mask register only while in IDLE; config_in.valid in any other state is ignored.
REQ-012 SHALL leave IDLE for HEADER on the cycle after any enabled source asserts valid; a zero mask keeps the FSM in IDLE.
REQ-013 SHALL drive in HEADER: data_out.valid=1, last=0, data = {HEADER_MAGIC in [W-1:W-16], N_SOURCES in [23:16], mask zero-extended in [15:0], zeros elsewhere}.
REQ-014 SHALL go from HEADER to STREAM on handshake (valid&ready), selecting the lowest-index enabled source.
REQ-015 SHALL in STREAM pass data_out.data/valid combinationally from the selected source, with last forced to 0, and source ready = data_out.ready; zero-cycle latency.
REQ-016 SHALL hold ready=0 on every unselected source and on all sources outside STREAM.
REQ-017 SHALL increment the selected source's beat counter on each handshake, saturating at 2^COUNT_WIDTH-1.
REQ-018 SHALL, on handshake of a beat with source last=1, select the next higher-index enabled source, or enter TRAILER if none remains.
REQ-019 SHALL drive in TRAILER: valid=1, last=1, data bits [i*COUNT_WIDTH +: COUNT_WIDTH] = count of source i (0 for disabled sources), upper bits zero.
REQ-020 SHALL return to IDLE on TRAILER handshake, clearing all counters in the same edge.
REQ-021 SHALL hold data_out.data stable while valid=1 and ready=0 in HEADER and TRAILER.
REQ-022 SHALL count a single-beat source (valid&last on first beat) as 1 and advance after that beat.
REQ-023 SHALL not alter the mask or selection while a beat is stalled (valid=1, ready=0).

Reset
REQ-024 SHALL, when reset=1 at a clock edge, enter IDLE, clear mask to all-ones, clear all counters, and drive data_out.valid=0, data_out.last=0, all source ready=0 from the next cycle.
REQ-025 SHALL abandon any in-progress sequence on reset with no trailer emitted; partial source beats are not replayed.

Verification
REQ-026 SHALL cover N_SOURCES=2, mask=2'b11, src0 3 beats, src1 2 beats, ready=1 -> header 0xA55A/0x02/0x3, 5 data beats in order, trailer {..,0x0002,0x0003} with last=1; 7 output beats.
REQ-027 SHALL cover mask=2'b10 with src0 valid asserted -> src0 ready never high, FSM stays IDLE until src1 valid; trailer count0=0, count1=N.
REQ-028 SHALL cover random data_out.ready backpressure (50%) -> data/last stable during stalls, beat order and counts unchanged versus ready=1 run.
REQ-029 SHALL cover reset asserted mid-STREAM after 2 of 4 src0 beats -> next cycle valid=0, all ready=0; next sequence header and counts start from zero.
REQ-030 SHALL cover COUNT_WIDTH=4 with 20 beats on src0 -> trailer count0=0xF, all 20 beats forwarded.
REQ-031 SHALL cover config_in.valid pulse (mask=2'b01) during STREAM -> ignored; current sequence unaffected; new mask applies only if re-sent in IDLE.
